// File: rtl/load_sequencer_pkg.sv
// Shared types for the load sequencer: data word, access size, FSM states and lane helpers.
package load_sequencer_pkg;

   localparam int unsigned WORD_W  = 64;
   localparam int unsigned LANE_W  = 3;
   localparam int unsigned NBYTE_W = 4;

   typedef logic [WORD_W-1:0] ulong_t;

   typedef enum logic [1:0] {
      BITS_8,
      BITS_16,
      BITS_32,
      BITS_64
   } sizeFlags_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE0,
      WAIT0,
      ISSUE1,
      WAIT1,
      RESP
   } state_t;

   function automatic logic [NBYTE_W-1:0] size_bytes(input sizeFlags_t size);
      logic [NBYTE_W-1:0] n;
      case (size)
         BITS_8:  n = NBYTE_W'(1);
         BITS_16: n = NBYTE_W'(2);
         BITS_32: n = NBYTE_W'(4);
         default: n = NBYTE_W'(8);
      endcase
      return n;
   endfunction

   // True when the access spills past the end of its doubleword.
   function automatic logic crosses(input logic [LANE_W-1:0] off, input sizeFlags_t size);
      return (NBYTE_W'(off) + size_bytes(size)) > NBYTE_W'(8);
   endfunction

endpackage

// File: rtl/load_sequencer_ivalue.sv
// IValue: truncates a right-justified load value to its access size and sign/zero-extends it.
module IValue
   import load_sequencer_pkg::*;
(
   input  ulong_t     raw,
   input  sizeFlags_t size,
   input  logic       sign,
   output ulong_t     value_c
);

   always_comb begin
      value_c = raw;
      case (size)
         BITS_8:  value_c = {{56{sign & raw[7]}},  raw[7:0]};
         BITS_16: value_c = {{48{sign & raw[15]}}, raw[15:0]};
         BITS_32: value_c = {{32{sign & raw[31]}}, raw[31:0]};
         default: value_c = raw;
      endcase
   end

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: issues one or two aligned doubleword reads per load and returns the extended result.
// LOAD_MISALIGN_EN: when defined, doubleword-crossing loads use two reads; otherwise they fault.
module load_sequencer
   import load_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  sizeFlags_t        req_size,
   input  logic              req_sign,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  ulong_t            mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output ulong_t            resp_data,
   output logic              resp_fault
);

   localparam int unsigned SHAMT_W = 7;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   sizeFlags_t        size_q;
   logic              sign_q;
   logic              load_req;

   logic              req_ready_d, mem_valid_d, resp_valid_d, resp_fault_d;
   logic [ADDR_W-1:0] mem_addr_d;
   ulong_t            resp_data_d;

   logic [LANE_W-1:0] off_c;
   logic              cross_c;
   logic [ADDR_W-1:0] aligned_c;
   ulong_t            word0_c;
   ulong_t            raw_c;
   ulong_t            ext_c;

   assign off_c     = addr_q[LANE_W-1:0];
   assign cross_c   = crosses(off_c, size_q);
   assign aligned_c = {addr_q[ADDR_W-1:LANE_W], LANE_W'(0)};

`ifdef LOAD_MISALIGN_EN
   ulong_t word0_q;
   logic   cap_word0;

   // In WAIT1 the low part comes from the stored first word, the high part from the live second read.
   assign word0_c = (state_q == WAIT0) ? mem_rdata : word0_q;

   always_comb begin
      raw_c = word0_c >> {off_c, 3'b000};
      if (cross_c && state_q == WAIT1) begin
         raw_c = raw_c | (mem_rdata << (SHAMT_W'(64) - SHAMT_W'({off_c, 3'b000})));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word0_q <= '0;
      end else if (cap_word0) begin
         word0_q <= mem_rdata;
      end
   end
`else
   logic req_cross_c;

   assign req_cross_c = crosses(req_addr[LANE_W-1:0], req_size);
   assign word0_c     = mem_rdata;
   assign raw_c       = word0_c >> {off_c, 3'b000};
`endif

   IValue u_ivalue (
      .raw     (raw_c),
      .size    (size_q),
      .sign    (sign_q),
      .value_c (ext_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d      = state_q;
      mem_valid_d  = mem_valid;
      mem_addr_d   = mem_addr;
      resp_valid_d = resp_valid;
      resp_data_d  = resp_data;
      resp_fault_d = resp_fault;
      load_req     = 1'b0;
`ifdef LOAD_MISALIGN_EN
      cap_word0    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d     = ISSUE0;
               load_req    = 1'b1;
               mem_valid_d = 1'b1;
               mem_addr_d  = {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
`ifndef LOAD_MISALIGN_EN
               if (req_cross_c) mem_valid_d = 1'b0;
`endif
            end
         end
         ISSUE0: begin
`ifndef LOAD_MISALIGN_EN
            if (cross_c) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = '0;
               resp_fault_d = 1'b1;
            end else
`endif
            if (mem_ready) begin
               state_d     = WAIT0;
               mem_valid_d = 1'b0;
            end
         end
         WAIT0: begin
            if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_EN
               cap_word0 = 1'b1;
               if (cross_c) begin
                  state_d     = ISSUE1;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = aligned_c + ADDR_W'(8);
               end else
`endif
               begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_data_d  = ext_c;
                  resp_fault_d = 1'b0;
               end
            end
         end
`ifdef LOAD_MISALIGN_EN
         ISSUE1: begin
            if (mem_ready) begin
               state_d     = WAIT1;
               mem_valid_d = 1'b0;
            end
         end
         WAIT1: begin
            if (mem_rvalid) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = ext_c;
               resp_fault_d = 1'b0;
            end
         end
`endif
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         req_ready  <= 1'b1;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_fault <= 1'b0;
         addr_q     <= '0;
         size_q     <= BITS_8;
         sign_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_ready  <= req_ready_d;
         mem_valid  <= mem_valid_d;
         mem_addr   <= mem_addr_d;
         resp_valid <= resp_valid_d;
         resp_data  <= resp_data_d;
         resp_fault <= resp_fault_d;
         if (load_req) begin
            addr_q <= req_addr;
            size_q <= req_size;
            sign_q <= req_sign;
         end
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer; expectations follow LOAD_MISALIGN_EN as compiled.
module tb_load_sequencer;
   import load_sequencer_pkg::*;

`ifdef LOAD_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic       clk, reset;
   logic       req_valid, req_ready, req_sign;
   ulong_t     req_addr, mem_addr, mem_rdata, resp_data;
   sizeFlags_t req_size;
   logic       mem_valid, mem_ready, mem_rvalid;
   logic       resp_valid, resp_ready, resp_fault;

   load_sequencer #(.ADDR_W(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_sign   (req_sign),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_fault (resp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_mis = 0;

   ulong_t exp_addr_q[$];
   ulong_t obs_addr_q[$];
   ulong_t mem_data_q[$];
   ulong_t exp_data_q[$];
   logic   exp_fault_q[$];

   ulong_t obs_data;
   logic   obs_fault;
   int     obs_lat;
   bit     obs_timeout, addr_moved, data_moved, busy_seen, noise_en;

   // Reference: pick bytes out of a 16-byte window, then extend.
   function automatic ulong_t model_data(ulong_t addr, sizeFlags_t size, bit sign, ulong_t w0, ulong_t w1);
      logic [7:0] b[16];
      int         off = int'(addr[2:0]);
      int         n   = 1 << int'(size);
      ulong_t     r   = '0;
      for (int i = 0; i < 8; i++) begin
         b[i]     = w0[8*i +: 8];
         b[i + 8] = w1[8*i +: 8];
      end
      for (int i = 0; i < n; i++) r[8*i +: 8] = b[off + i];
      if (sign && n < 8 && r[8*n - 1]) begin
         for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
      end
      return r;
   endfunction

   function automatic bit is_cross(ulong_t addr, sizeFlags_t size);
      return (int'(addr[2:0]) + (1 << int'(size))) > 8;
   endfunction

   function automatic void push_expected(ulong_t addr, sizeFlags_t size, bit sign, ulong_t w0, ulong_t w1);
      ulong_t base = addr & ~64'h7;
      bit     cr   = is_cross(addr, size);
      if (!cr || MIS_EN) begin
         exp_addr_q.push_back(base);
         mem_data_q.push_back(w0);
         if (cr) begin
            exp_addr_q.push_back(base + 64'd8);
            mem_data_q.push_back(w1);
         end
         exp_data_q.push_back(model_data(addr, size, sign, w0, w1));
         exp_fault_q.push_back(1'b0);
      end else begin
         exp_data_q.push_back('0);
         exp_fault_q.push_back(1'b1);
      end
   endfunction

   // Drives one load and acts as memory and consumer; records what the DUT did.
   task automatic run_load(ulong_t addr, sizeFlags_t size, bit sign, int mem_stall, int resp_stall);
      int     c = 0, ms = 0, rs = 0;
      bit     pending = 0, got = 0, done = 0, prev_v = 0;
      ulong_t prev_a = '0;
      obs_addr_q.delete();
      addr_moved = 0; data_moved = 0; busy_seen = 0;
      obs_data = '0; obs_fault = 1'b0; obs_lat = -1;
      @(negedge clk);
      req_valid = 1'b1; req_addr = addr; req_size = size; req_sign = sign;
      @(negedge clk);
      req_valid = 1'b0;
      while (!done && c < 200) begin
         c++;
         if (pending) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : '0;
            pending    = 0;
         end else begin
            mem_rvalid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = {$urandom, $urandom};
         end
         if (mem_valid) begin
            if (prev_v && mem_addr !== prev_a) addr_moved = 1;
            prev_v = 1; prev_a = mem_addr;
            if (ms >= mem_stall) begin
               mem_ready = 1'b1;
               obs_addr_q.push_back(mem_addr);
               pending = 1; ms = 0; prev_v = 0;
            end else begin
               mem_ready = 1'b0;
               ms++;
            end
         end else begin
            mem_ready = 1'b0;
            prev_v = 0;
         end
         if (resp_valid) begin
            if (!got) begin
               got = 1; obs_data = resp_data; obs_fault = resp_fault; obs_lat = c;
            end else if (resp_data !== obs_data || resp_fault !== obs_fault) begin
               data_moved = 1;
            end
            if (rs >= resp_stall) begin
               resp_ready = 1'b1; done = 1;
            end else begin
               resp_ready = 1'b0; rs++;
            end
         end else begin
            resp_ready = 1'b0;
         end
         if (req_ready) busy_seen = 1;
         @(negedge clk);
      end
      resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      obs_timeout = !done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp += 6;
      if (req_ready !== 1'b1)  begin n_mis++; $display("FAIL reset.req_ready got %b want 1", req_ready); end
      if (mem_valid !== 1'b0)  begin n_mis++; $display("FAIL reset.mem_valid got %b want 0", mem_valid); end
      if (mem_addr !== '0)     begin n_mis++; $display("FAIL reset.mem_addr got %h want 0", mem_addr); end
      if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL reset.resp_valid got %b want 0", resp_valid); end
      if (resp_data !== '0)    begin n_mis++; $display("FAIL reset.resp_data got %h want 0", resp_data); end
      if (resp_fault !== 1'b0) begin n_mis++; $display("FAIL reset.resp_fault got %b want 0", resp_fault); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset.req_ready got %b want 1", req_ready); end
   endtask

   task automatic test_byte_sign();
      ulong_t ea, oa, ed;
      logic   ef;
      push_expected(64'h1003, BITS_8, 1'b1, 64'h00000000_80000000, '0);
      run_load(64'h1003, BITS_8, 1'b1, 0, 0);
      while (exp_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); n_cmp++;
         if (obs_addr_q.size() == 0) begin n_mis++; $display("FAIL byte.mem_addr got none want %h", ea); end
         else begin oa = obs_addr_q.pop_front(); if (oa !== ea) begin n_mis++; $display("FAIL byte.mem_addr got %h want %h", oa, ea); end end
      end
      ed = exp_data_q.pop_front(); ef = exp_fault_q.pop_front();
      n_cmp += 5;
      if (obs_addr_q.size() != 0) begin n_mis++; $display("FAIL byte.extra_reads got %0d want 0", obs_addr_q.size()); end
      if (obs_data !== ed)  begin n_mis++; $display("FAIL byte.resp_data got %h want %h", obs_data, ed); end
      if (obs_fault !== ef) begin n_mis++; $display("FAIL byte.resp_fault got %b want %b", obs_fault, ef); end
      if (obs_timeout)      begin n_mis++; $display("FAIL byte.timeout got 1 want 0"); end
      if (obs_lat != 3)     begin n_mis++; $display("FAIL byte.latency got %0d want 3", obs_lat); end
   endtask

   task automatic test_cross();
      ulong_t ea, oa, ed;
      logic   ef;
      push_expected(64'h2006, BITS_32, 1'b0, 64'hBBAA0000_00000000, 64'h00000000_0000DDCC);
      run_load(64'h2006, BITS_32, 1'b0, 0, 0);
      while (exp_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); n_cmp++;
         if (obs_addr_q.size() == 0) begin n_mis++; $display("FAIL cross.mem_addr got none want %h", ea); end
         else begin oa = obs_addr_q.pop_front(); if (oa !== ea) begin n_mis++; $display("FAIL cross.mem_addr got %h want %h", oa, ea); end end
      end
      ed = exp_data_q.pop_front(); ef = exp_fault_q.pop_front();
      n_cmp += 4;
      if (obs_addr_q.size() != 0) begin n_mis++; $display("FAIL cross.extra_reads got %0d want 0", obs_addr_q.size()); end
      if (obs_data !== ed)  begin n_mis++; $display("FAIL cross.resp_data got %h want %h", obs_data, ed); end
      if (obs_fault !== ef) begin n_mis++; $display("FAIL cross.resp_fault got %b want %b", obs_fault, ef); end
      if (obs_timeout)      begin n_mis++; $display("FAIL cross.timeout got 1 want 0"); end
      if (MIS_EN) begin
         n_cmp++;
         if (obs_lat != 5) begin n_mis++; $display("FAIL cross.latency got %0d want 5", obs_lat); end
      end
      mem_data_q.delete();
   endtask

   task automatic test_wrap();
      ulong_t ea, oa, ed;
      logic   ef;
      push_expected(64'hFFFFFFFF_FFFFFFFC, BITS_64, 1'b0, 64'h11223344_55667788, 64'h99AABBCC_DDEEFF00);
      run_load(64'hFFFFFFFF_FFFFFFFC, BITS_64, 1'b0, 0, 0);
      while (exp_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); n_cmp++;
         if (obs_addr_q.size() == 0) begin n_mis++; $display("FAIL wrap.mem_addr got none want %h", ea); end
         else begin oa = obs_addr_q.pop_front(); if (oa !== ea) begin n_mis++; $display("FAIL wrap.mem_addr got %h want %h", oa, ea); end end
      end
      ed = exp_data_q.pop_front(); ef = exp_fault_q.pop_front();
      n_cmp += 4;
      if (obs_addr_q.size() != 0) begin n_mis++; $display("FAIL wrap.extra_reads got %0d want 0", obs_addr_q.size()); end
      if (obs_data !== ed)  begin n_mis++; $display("FAIL wrap.resp_data got %h want %h", obs_data, ed); end
      if (obs_fault !== ef) begin n_mis++; $display("FAIL wrap.resp_fault got %b want %b", obs_fault, ef); end
      if (obs_timeout)      begin n_mis++; $display("FAIL wrap.timeout got 1 want 0"); end
      mem_data_q.delete();
   endtask

   task automatic test_stall();
      ulong_t ea, oa, ed;
      logic   ef;
      noise_en = 1'b1;
      push_expected(64'h3002, BITS_16, 1'b1, 64'h0000_0000_F00D_0000, '0);
      run_load(64'h3002, BITS_16, 1'b1, 4, 3);
      noise_en = 1'b0;
      while (exp_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); n_cmp++;
         if (obs_addr_q.size() == 0) begin n_mis++; $display("FAIL stall.mem_addr got none want %h", ea); end
         else begin oa = obs_addr_q.pop_front(); if (oa !== ea) begin n_mis++; $display("FAIL stall.mem_addr got %h want %h", oa, ea); end end
      end
      ed = exp_data_q.pop_front(); ef = exp_fault_q.pop_front();
      n_cmp += 6;
      if (obs_data !== ed)  begin n_mis++; $display("FAIL stall.resp_data got %h want %h", obs_data, ed); end
      if (obs_fault !== ef) begin n_mis++; $display("FAIL stall.resp_fault got %b want %b", obs_fault, ef); end
      if (addr_moved)       begin n_mis++; $display("FAIL stall.mem_addr_stable got moved want held"); end
      if (data_moved)       begin n_mis++; $display("FAIL stall.resp_stable got moved want held"); end
      if (busy_seen)        begin n_mis++; $display("FAIL stall.req_ready got 1 while busy want 0"); end
      if (obs_timeout)      begin n_mis++; $display("FAIL stall.timeout got 1 want 0"); end
   endtask

   task automatic test_reset_midflight();
      bit saw_resp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 64'h1003; req_size = BITS_8; req_sign = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++;
      if (mem_valid !== 1'b1) begin n_mis++; $display("FAIL midreset.issue mem_valid got %b want 1", mem_valid); end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp += 2;
      if (req_ready !== 1'b1) begin n_mis++; $display("FAIL midreset.req_ready got %b want 1", req_ready); end
      if (mem_addr !== '0)    begin n_mis++; $display("FAIL midreset.mem_addr got %h want 0", mem_addr); end
      @(negedge clk);
      reset = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 64'h00000000_80000000;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid) saw_resp = 1;
         @(negedge clk);
      end
      n_cmp += 3;
      if (saw_resp)           begin n_mis++; $display("FAIL midreset.resp_valid got 1 want 0"); end
      if (req_ready !== 1'b1) begin n_mis++; $display("FAIL midreset.idle req_ready got %b want 1", req_ready); end
      if (mem_valid !== 1'b0) begin n_mis++; $display("FAIL midreset.mem_valid got %b want 0", mem_valid); end
   endtask

   task automatic test_back_to_back();
      ulong_t     ea, oa, ed, a, w0, w1;
      logic       ef;
      sizeFlags_t sz;
      bit         sg;
      int         mst, rst_stall;
      for (int k = 0; k < 24; k++) begin
         a   = {$urandom, $urandom};
         sz  = sizeFlags_t'($urandom_range(0, 3));
         sg  = 1'($urandom_range(0, 1));
         w0  = {$urandom, $urandom};
         w1  = {$urandom, $urandom};
         mst = $urandom_range(0, 2);
         rst_stall = $urandom_range(0, 2);
         push_expected(a, sz, sg, w0, w1);
         run_load(a, sz, sg, mst, rst_stall);
         while (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front(); n_cmp++;
            if (obs_addr_q.size() == 0) begin n_mis++; $display("FAIL b2b[%0d].mem_addr got none want %h", k, ea); end
            else begin oa = obs_addr_q.pop_front(); if (oa !== ea) begin n_mis++; $display("FAIL b2b[%0d].mem_addr got %h want %h", k, oa, ea); end end
         end
         ed = exp_data_q.pop_front(); ef = exp_fault_q.pop_front();
         n_cmp += 4;
         if (obs_addr_q.size() != 0) begin n_mis++; $display("FAIL b2b[%0d].extra_reads got %0d want 0", k, obs_addr_q.size()); end
         if (obs_data !== ed)  begin n_mis++; $display("FAIL b2b[%0d].resp_data got %h want %h", k, obs_data, ed); end
         if (obs_fault !== ef) begin n_mis++; $display("FAIL b2b[%0d].resp_fault got %b want %b", k, obs_fault, ef); end
         if (obs_timeout)      begin n_mis++; $display("FAIL b2b[%0d].timeout got 1 want 0", k); end
         mem_data_q.delete();
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = BITS_8; req_sign = 1'b0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0; noise_en = 1'b0;
      test_reset();
      test_byte_sign();
      test_cross();
      test_wrap();
      test_stall();
      test_reset_midflight();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, load address width in bits (low 3 bits select byte lane).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  load request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_addr  input  ADDR_W  byte address of load.
REQ-007 SHALL have port req_size  input  sizeFlags_t  BITS_8/16/32/64 access size.
REQ-008 SHALL have port req_sign  input  1  sign-extend result when high, zero-extend when low.
REQ-009 SHALL have port mem_valid  output  1  memory read address valid.
REQ-010 SHALL have port mem_ready  input  1  memory accepts address this cycle.
REQ-011 SHALL have port mem_addr  output  ADDR_W  8-byte-aligned read address.
REQ-012 SHALL have port mem_rvalid  input  1  read data returned this cycle.
REQ-013 SHALL have port mem_rdata  input  64  returned doubleword (ulong_t), byte 0 in bits 7:0.
REQ-014 SHALL have port resp_valid  output  1  result available.
REQ-015 SHALL have port resp_ready  input  1  consumer takes result.
REQ-016 SHALL have port resp_data  output  64  extended load result (ulong_t).
REQ-017 SHALL have port resp_fault  output  1  misaligned-access fault flag, qualified by resp_valid.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
REQ-019 SHALL drive req_ready high only in IDLE; on req_valid&&req_ready latch addr/size/sign and go to ISSUE0 next cycle.
REQ-020 SHALL compute off = addr[2:0], nbytes = 1/2/4/8 per size, cross = (off + nbytes > 8).
REQ-021 SHALL in ISSUE0 drive mem_valid=1, mem_addr = addr with bits 2:0 cleared; hold both stable until mem_ready, then go to WAIT0.
REQ-022 SHALL in WAIT0 capture mem_rdata on mem_rvalid as word0; go to ISSUE1 if cross, else RESP.
REQ-023 SHALL in ISSUE1 drive mem_addr = aligned addr + 8 modulo 2^ADDR_W (wraps to 0 at top of space); WAIT1 captures word1 then goes to RESP.
REQ-024 SHALL form raw = word0 >> (8*off), OR'd with word1 << (8*(8-off)) when cross; then truncate to size and extend per req_sign (BITS_64 passes unchanged).
REQ-025 SHALL hold resp_valid, resp_data, resp_fault stable in RESP until resp_ready, then return to IDLE; no new request accepted in the same cycle.
REQ-026 SHALL ignore mem_rvalid outside WAIT0/WAIT1 and mem_ready outside ISSUE0/ISSUE1.
REQ-027 SHALL give minimum latency (mem_ready and mem_rvalid each in first possible cycle) of 3 cycles accept-to-resp_valid non-crossing, 5 crossing.

Reset
REQ-028 SHALL on reset, at any state, go to IDLE asynchronously with req_ready=1, mem_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_fault=0.
REQ-029 SHALL drop any in-flight load on reset; late mem_rvalid after reset is ignored per REQ-026.

Configuration
REQ-030 SHALL with LOAD_MISALIGN_EN defined perform crossing loads as two reads per REQ-022/023.
REQ-031 SHALL without LOAD_MISALIGN_EN go from ISSUE0 directly to RESP for crossing loads, issuing no memory read, with resp_fault=1 and resp_data=0; ISSUE1/WAIT1 logic compiled out.

Structure
REQ-032 SHALL place the FSM state enum in the shared types package beside ulong_t and sizeFlags_t.
REQ-033 SHALL instantiate IValue as its single sub-module for truncate/extend; all other logic local.

Verification
REQ-034 SHALL cover: addr 0x1003, BITS_8, sign=1, word0 0x00000000_80000000 -> one read at 0x1000, resp_data 0xFFFFFFFF_FFFFFF80, fault 0.
REQ-035 SHALL cover: addr 0x2006, BITS_32, sign=0, word0 0xBBAA0000_00000000, word1 0x00000000_0000DDCC (macro on) -> reads 0x2000, 0x2008, resp_data 0x00000000_DDCCBBAA.
REQ-036 SHALL cover: same as REQ-035 with macro off -> no mem_valid, resp_fault=1, resp_data 0.
REQ-037 SHALL cover: addr 0xFFFFFFFF_FFFFFFFC, BITS_64, macro on -> second mem_addr 0x0 (wrap).
REQ-038 SHALL cover: mem_ready low 4 cycles, resp_ready low 3 cycles -> mem_addr and resp_data held stable, req_ready stays 0.
REQ-039 SHALL cover: reset asserted in WAIT0, mem_rvalid arrives next cycle -> IDLE, resp_valid never asserted.
